// File: rtl/instruction_encoder.sv
// MIPS32 instruction encoder: packs encode requests into instruction words,
// expands LI32 into LUI+ORI, and queues words in a FIFO for the fetch path.
`default_nettype none

module instruction_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_op,
  input  logic [4:0]               req_rs,
  input  logic [4:0]               req_rt,
  input  logic [4:0]               req_rd,
  input  logic [31:0]              req_imm,
  output logic                     req_err,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic                     inst_last,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] OP_LI32 = 4'd10;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t          state, state_d;
  logic [32:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     pend_ori;
  logic [31:0]     push_word;
  logic            push_last, push, pop, pend_load;
  logic            full, accept, reserved, two_word;

  function automatic logic [31:0] encode_word0(input logic [3:0]  op,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [4:0]  rd,
                                               input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      4'd1:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      4'd2:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd3:  w = {6'b001001, rs, rt, imm[15:0]};
      4'd4:  w = {6'b001101, rs, rt, imm[15:0]};
      4'd5:  w = {6'b001111, 5'b00000, rt, imm[15:0]};
      4'd6:  w = {6'b000100, rs, rt, imm[15:0]};
      4'd7:  w = {6'b000101, rs, rt, imm[15:0]};
      4'd8:  w = {6'b000010, imm[27:2]};
      4'd9:  w = {6'b000011, imm[27:2]};
      // Short LI32 collapses to ORI from $0; long form starts with LUI.
      4'd10: w = (imm[31:16] == 16'h0) ? {6'b001101, 5'b00000, rt, imm[15:0]}
                                       : {6'b001111, 5'b00000, rt, imm[31:16]};
      default: w = '0;
    endcase
    encode_word0 = w;
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? mem[rd_ptr][31:0] : '0;
  assign inst_last  = inst_valid ? mem[rd_ptr][32] : 1'b0;
  assign req_ready  = (state == IDLE) && !flush && !full;
  assign accept     = req_valid && req_ready;
  assign reserved   = (req_op > OP_LI32);
  assign two_word   = (req_op == OP_LI32) && (req_imm[31:16] != 16'h0);
  assign pop        = inst_ready && inst_valid && !flush;

  always_comb begin
    state_d   = state;
    push      = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    pend_load = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !reserved) begin
          push      = 1'b1;
          push_word = encode_word0(req_op, req_rs, req_rt, req_rd, req_imm);
          push_last = !two_word;
          if (two_word) begin
            pend_load = 1'b1;
            state_d   = SECOND;
          end
        end
      end
      SECOND: begin
        // Registered count gates the push, so a same-cycle pop does not help.
        if (!full) begin
          push      = 1'b1;
          push_word = pend_ori;
          push_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      req_err <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      req_err <= 1'b0;
    end else begin
      state   <= state_d;
      count   <= count + CW'(push) - CW'(pop);
      req_err <= accept && reserved;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage holds data only; validity is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push)      mem[wr_ptr] <= {push_last, push_word};
    if (pend_load) pend_ori    <= {6'b001101, req_rt, req_rt, req_imm[15:0]};
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: table of single/two-word encodings
// plus hand sequences for full FIFO, held expansion, flush, reserved ops, reset.
`timescale 1ns/1ps

module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [31:0] req_imm;
  logic        req_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_last;
  logic [2:0]  count;

  int applied = 0;
  int miscompares = 0;

  instruction_encoder #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_err(req_err), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_last(inst_last), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        two;
    logic [31:0] w0, w1;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string n, logic [3:0] op, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rd, logic [31:0] imm, logic two,
                              logic [31:0] w0, logic [31:0] w1);
    vec_t v;
    v.name = n; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm;
    v.two = two; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(logic [3:0] op, logic [4:0] rs, logic [4:0] rt,
                           logic [4:0] rd, logic [31:0] imm);
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_count"},      32'(count), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},       inst, 32'd0);
    chk({tag, "_inst_last"},  32'(inst_last), 32'd0);
    chk({tag, "_req_err"},    32'(req_err), 32'd0);
    chk({tag, "_req_ready"},  32'(req_ready), 32'd1);
  endtask

  // Queue n ADDIU rt=5 rs=0 with imm = base+i while the consumer stalls.
  task automatic fill_addiu(int n, logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      drive_req(4'd3, 5'd0, 5'd5, 5'd0, {16'h0, base + 16'(i)});
      step();
    end
    idle_req();
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    idle_req();

    vecs[0]  = mk("nop",       4'd0,  5'd7,  5'd9,  5'd11, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0);
    vecs[1]  = mk("addu",      4'd1,  5'd1,  5'd2,  5'd3,  32'h0,         1'b0, 32'h0022_1821, 32'h0);
    vecs[2]  = mk("subu",      4'd2,  5'd4,  5'd5,  5'd6,  32'h0,         1'b0, 32'h0085_3023, 32'h0);
    vecs[3]  = mk("addu_r31",  4'd1,  5'd31, 5'd31, 5'd31, 32'h0,         1'b0, 32'h03FF_F821, 32'h0);
    vecs[4]  = mk("addiu",     4'd3,  5'd0,  5'd5,  5'd0,  32'h0000_FFFF, 1'b0, 32'h2405_FFFF, 32'h0);
    vecs[5]  = mk("ori",       4'd4,  5'd3,  5'd7,  5'd0,  32'h0000_1234, 1'b0, 32'h3467_1234, 32'h0);
    vecs[6]  = mk("lui",       4'd5,  5'd31, 5'd9,  5'd0,  32'h0000_ABCD, 1'b0, 32'h3C09_ABCD, 32'h0);
    vecs[7]  = mk("beq",       4'd6,  5'd1,  5'd2,  5'd0,  32'h0000_0010, 1'b0, 32'h1022_0010, 32'h0);
    vecs[8]  = mk("bne",       4'd7,  5'd1,  5'd2,  5'd0,  32'h0000_FFFE, 1'b0, 32'h1422_FFFE, 32'h0);
    vecs[9]  = mk("j",         4'd8,  5'd0,  5'd0,  5'd0,  32'h0040_0000, 1'b0, 32'h0810_0000, 32'h0);
    vecs[10] = mk("jal",       4'd9,  5'd0,  5'd0,  5'd0,  32'h0040_0020, 1'b0, 32'h0C10_0008, 32'h0);
    vecs[11] = mk("li32_short",4'd10, 5'd0,  5'd4,  5'd0,  32'h0000_BEEF, 1'b0, 32'h3404_BEEF, 32'h0);
    vecs[12] = mk("li32_long", 4'd10, 5'd0,  5'd8,  5'd0,  32'h1234_5678, 1'b1, 32'h3C08_1234, 32'h3508_5678);
    vecs[13] = mk("li32_hi",   4'd10, 5'd0,  5'd1,  5'd0,  32'hFFFF_0000, 1'b1, 32'h3C01_FFFF, 32'h3421_0000);

    #12;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    inst_ready = 1'b1;
    foreach (vecs[i]) begin
      chk({vecs[i].name, "_ready_in"}, 32'(req_ready), 32'd1);
      drive_req(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
      step();
      idle_req();
      chk({vecs[i].name, "_valid0"}, 32'(inst_valid), 32'd1);
      chk({vecs[i].name, "_w0"},     inst, vecs[i].w0);
      chk({vecs[i].name, "_last0"},  32'(inst_last), 32'(!vecs[i].two));
      chk({vecs[i].name, "_count0"}, 32'(count), 32'd1);
      if (vecs[i].two) begin
        chk({vecs[i].name, "_ready_2nd"}, 32'(req_ready), 32'd0);
        step();
        chk({vecs[i].name, "_w1"},     inst, vecs[i].w1);
        chk({vecs[i].name, "_last1"},  32'(inst_last), 32'd1);
        chk({vecs[i].name, "_count1"}, 32'(count), 32'd1);
      end
      step();
      chk({vecs[i].name, "_drained"}, 32'(count), 32'd0);
    end

    // Fill to DEPTH with the consumer stalled, then drain in order.
    inst_ready = 1'b0;
    fill_addiu(4, 16'hFFFF);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_head",  inst, 32'h2405_FFFF);
    drive_req(4'd3, 5'd0, 5'd5, 5'd0, 32'h0000_0077);
    step();
    idle_req();
    chk("full_no_push", 32'(count), 32'd4);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_head%0d", i), inst, {16'h2405, 16'hFFFF + 16'(i)});
      step();
      chk($sformatf("drain_count%0d", i), 32'(count), 32'(3 - i));
    end
    chk("drain_empty_valid", 32'(inst_valid), 32'd0);
    step();
    chk("pop_empty_count", 32'(count), 32'd0);

    // LI32 into count=3: LUI fills the FIFO, ORI waits for room.
    inst_ready = 1'b0;
    fill_addiu(3, 16'h0010);
    drive_req(4'd10, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    step();
    idle_req();
    chk("hold_count_a", 32'(count), 32'd4);
    chk("hold_ready",   32'(req_ready), 32'd0);
    step();
    chk("hold_count_b", 32'(count), 32'd4);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("hold_pop_count", 32'(count), 32'd3);
    step();
    chk("hold_ori_count", 32'(count), 32'd4);
    inst_ready = 1'b1;
    chk("hold_seq0", inst, 32'h2405_0011);
    step();
    chk("hold_seq1", inst, 32'h2405_0012);
    step();
    chk("hold_seq2", inst, 32'h3C08_1234);
    chk("hold_seq2_last", 32'(inst_last), 32'd0);
    step();
    chk("hold_seq3", inst, 32'h3508_5678);
    chk("hold_seq3_last", 32'(inst_last), 32'd1);
    step();
    chk("hold_empty", 32'(count), 32'd0);

    // Flush while the ORI is pending.
    inst_ready = 1'b0;
    fill_addiu(3, 16'h0020);
    drive_req(4'd10, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    step();
    idle_req();
    chk("flush_pre_count", 32'(count), 32'd4);
    flush = 1'b1;
    #1;
    chk("flush_ready_comb", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_ready", 32'(req_ready), 32'd1);
    inst_ready = 1'b1;
    step();
    step();
    chk("flush_no_ori", 32'(inst_valid), 32'd0);

    // Reserved op: accepted, nothing queued, one-cycle req_err.
    inst_ready = 1'b0;
    fill_addiu(1, 16'h0030);
    drive_req(4'd15, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
    chk("rsv_ready", 32'(req_ready), 32'd1);
    step();
    idle_req();
    chk("rsv_err_hi", 32'(req_err), 32'd1);
    chk("rsv_count",  32'(count), 32'd1);
    step();
    chk("rsv_err_lo", 32'(req_err), 32'd0);
    chk("rsv_count2", 32'(count), 32'd1);
    chk("rsv_head",   inst, 32'h2405_0030);

    // Asynchronous reset mid-expansion.
    fill_addiu(2, 16'h0040);
    drive_req(4'd10, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    step();
    idle_req();
    chk("arst_pre_count", 32'(count), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    #3;
    reset_n = 1'b1;
    inst_ready = 1'b1;
    step();
    step();
    chk("arst_no_ori", 32'(inst_valid), 32'd0);
    chk("arst_count",  32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential MIPS32 instruction encoder: the write-side counterpart of the decode stage. It accepts abstract encode requests (operation class plus register/immediate fields), packs them into 32-bit instruction words, and expands the LI32 pseudo-op into one or two words. Words are buffered in a small FIFO and presented to the fetch/decode path over a valid/ready handshake. Used for debug-instruction injection and boot stub generation.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on its rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous clear of FIFO and pending expansion
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  4  operation class; see Operation
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  32  immediate / branch offset / jump address
- req_err  out  1  one-cycle pulse: reserved req_op was accepted
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  consumer takes head when inst_valid && inst_ready
- inst  out  32  head instruction word; 0 when inst_valid=0
- inst_last  out  1  head is the final word of its request; 0 when inst_valid=0
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Encodings (imm16 = req_imm[15:0]):
  - 0 NOP: 0x00000000
  - 1 ADDU: {000000, rs, rt, rd, 00000, 100001}
  - 2 SUBU: same layout as ADDU, funct 100011
  - 3 ADDIU: {001001, rs, rt, imm16}
  - 4 ORI: {001101, rs, rt, imm16}
  - 5 LUI: {001111, 00000, rt, imm16}
  - 6 BEQ: {000100, rs, rt, imm16}
  - 7 BNE: {000101, rs, rt, imm16}
  - 8 J: {000010, req_imm[27:2]}
  - 9 JAL: {000011, req_imm[27:2]}
  - 10 LI32 rt, imm32:
    - if req_imm[31:16]==0: single word ORI rt,$0,req_imm[15:0]
    - else: LUI rt,req_imm[31:16], then ORI rt,rt,req_imm[15:0]
  - 11-15 reserved: accepted and dropped; nothing pushed; req_err pulses the next cycle.
- FIFO entry = {inst_last, inst}; in-order; head drives inst/inst_last.
- FSM:
  - IDLE: req_ready = !flush && count<DEPTH. On accept: push word0; inst_last=1 unless LI32 two-word, in which case latch the ORI word and go to SECOND.
  - SECOND: req_ready=0. Push the latched ORI with inst_last=1 when count<DEPTH, then return to IDLE; otherwise hold.
- Full check uses registered count: no push when count==DEPTH, even if a pop occurs in the same cycle.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged, both take effect.
- Pop when empty: ignored.
- flush has priority over push and pop. Next cycle: count=0, state=IDLE, pending ORI discarded, req_err=0.
- Async reset has the same effect as flush and takes effect immediately, including mid-expansion.

## Timing
- Reset values: count=0, inst_valid=0, inst=0, inst_last=0, req_err=0, state=IDLE. req_ready=1 while flush=0.
- req_ready, inst_valid, inst and inst_last are combinational from registered state; no input-to-output combinational path except flush→req_ready.
- Latency: a request accepted in cycle N appears at the head in cycle N+1 if the FIFO was empty.
- Two-word LI32 into a non-full FIFO: LUI pushed at edge N, ORI at edge N+1. req_ready is low in cycle N+1.
- Throughput: one request per cycle for single-word ops; one word per cycle out.

## Test plan
- Reset, then ADDU rs=1 rt=2 rd=3 → next cycle inst_valid=1, inst=0x00221821, inst_last=1, count=1.
- LI32 rt=8 imm=0x12345678, inst_ready=1 → inst 0x3C081234 (inst_last=0), then 0x35085678 (inst_last=1); req_ready=0 in the second cycle.
- LI32 rt=4 imm=0x0000BEEF → single word 0x3404BEEF, inst_last=1. J imm=0x00400000 → 0x08100000.
- inst_ready=0, four ADDIU rt=5 rs=0 imm=0xFFFF → count=4, req_ready=0, inst=0x2405FFFF. Then inst_ready=1 → drained one per cycle in order, count 3,2,1,0.
- count=3, inst_ready=0, LI32 rt=8 imm=0x12345678 → LUI pushed, FSM holds SECOND. Pulse inst_ready for one cycle → ORI pushed the following edge; count returns to 4.
- flush while in SECOND → next cycle count=0, inst_valid=0, no ORI emitted, req_ready=1. req_op=15 → req_err pulses for one cycle, count unchanged. Assert reset_n low mid-stream → all outputs at reset values immediately.
